// File: rtl/wrnc_hmq_pkg.sv
// Shared register map, bit positions and slot state type for the host->CPU message-queue slot.
package wrnc_hmq_pkg;

  localparam logic [9:0] ADR_CMD     = 10'h000;
  localparam logic [9:0] ADR_STATUS  = 10'h001;
  localparam logic [9:0] ADR_ERR     = 10'h002;
  localparam logic [9:0] ADR_PAYLOAD = 10'h200;

  localparam int CMD_CLAIM  = 0;
  localparam int CMD_COMMIT = 1;
  localparam int CMD_PURGE  = 2;

  localparam int STAT_FULL        = 0;
  localparam int STAT_EMPTY       = 1;
  localparam int STAT_CLAIMED     = 2;
  localparam int STAT_COUNT_LSB   = 8;
  localparam int STAT_ENTRIES_LSB = 16;

  localparam int ERR_CLAIM_FULL       = 0;
  localparam int ERR_COMMIT_UNCLAIMED = 1;
  localparam int ERR_WRITE_UNCLAIMED  = 2;

  typedef enum logic {
    S_IDLE,
    S_CLAIMED
  } slot_state_t;

  function automatic logic [31:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       claimed,
                                              input logic [4:0] count,
                                              input logic [4:0] entries);
    logic [31:0] w;
    w                             = '0;
    w[STAT_FULL]                  = full;
    w[STAT_EMPTY]                 = empty;
    w[STAT_CLAIMED]               = claimed;
    w[STAT_COUNT_LSB +: 5]        = count;
    w[STAT_ENTRIES_LSB +: 5]      = entries;
    return w;
  endfunction

endpackage

// File: rtl/wrnc_hmq_dpram.sv
// Simple dual-port RAM: byte-enabled write port for the host, registered read port for the CPU.
module wrnc_hmq_dpram #(
  parameter int g_depth  = 64,
  parameter int g_addr_w = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [g_addr_w-1:0] waddr,
  input  logic [3:0]          sel,
  input  logic [31:0]         wdata,
  input  logic [g_addr_w-1:0] raddr,
  output logic [31:0]         rdata
);

  logic [31:0] mem [g_depth];

  // Read-before-write on address collision; the CPU never reads the entry being filled.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wrnc_hmq_in_slot.sv
// Wishbone slave for one host->CPU message-queue slot: claim/fill/commit from the host,
// FIFO-ordered read and discard of committed entries from the CPU.
module wrnc_hmq_in_slot
  import wrnc_hmq_pkg::*;
#(
  parameter int g_entries     = 4,
  parameter int g_entry_words = 16
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_sys_i,
  input  logic                             wb_cyc_i,
  input  logic                             wb_stb_i,
  input  logic                             wb_we_i,
  input  logic [3:0]                       wb_sel_i,
  input  logic [9:0]                       wb_adr_i,
  input  logic [31:0]                      wb_dat_i,
  output logic [31:0]                      wb_dat_o,
  output logic                             wb_ack_o,
  output logic                             wb_stall_o,
  output logic                             cpu_valid_o,
  input  logic [$clog2(g_entry_words)-1:0] cpu_rd_addr_i,
  output logic [31:0]                      cpu_rd_data_o,
  input  logic                             cpu_discard_i
);

  localparam int ENT_W  = $clog2(g_entries);
  localparam int WORD_W = $clog2(g_entry_words);
  localparam int PTR_W  = ENT_W + 1;
  localparam int RAM_AW = ENT_W + WORD_W;
  localparam logic [9:0] PAYLOAD_END = 10'(int'(ADR_PAYLOAD) + g_entry_words);

  slot_state_t      state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [2:0]       err;
  logic [2:0]       err_set;

  logic req, wr_req, rd_req;
  logic hit_cmd, hit_status, hit_err, hit_payload;
  logic cmd_wr, purge, claim_ok, commit_ok, discard_ok;
  logic full, empty, ram_we;

  assign req    = wb_cyc_i & wb_stb_i;
  assign wr_req = req & wb_we_i;
  assign rd_req = req & ~wb_we_i;

  assign hit_cmd     = (wb_adr_i == ADR_CMD);
  assign hit_status  = (wb_adr_i == ADR_STATUS);
  assign hit_err     = (wb_adr_i == ADR_ERR);
  assign hit_payload = (wb_adr_i >= ADR_PAYLOAD) && (wb_adr_i < PAYLOAD_END);

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PTR_W'(g_entries));
  assign empty = (count == '0);

  // PURGE masks the other command bits; COMMIT sees the state as left by a same-word CLAIM.
  assign cmd_wr     = wr_req & hit_cmd;
  assign purge      = cmd_wr & wb_dat_i[CMD_PURGE];
  assign claim_ok   = cmd_wr & ~wb_dat_i[CMD_PURGE] & wb_dat_i[CMD_CLAIM] & (state == S_IDLE) & ~full;
  assign commit_ok  = cmd_wr & ~wb_dat_i[CMD_PURGE] & wb_dat_i[CMD_COMMIT] &
                      ((state == S_CLAIMED) | claim_ok);
  assign discard_ok = cpu_discard_i & ~empty & ~purge;

  assign err_set[ERR_CLAIM_FULL]       = cmd_wr & ~wb_dat_i[CMD_PURGE] & wb_dat_i[CMD_CLAIM] &
                                         (state == S_IDLE) & full;
  assign err_set[ERR_COMMIT_UNCLAIMED] = cmd_wr & ~wb_dat_i[CMD_PURGE] & wb_dat_i[CMD_COMMIT] &
                                         ~((state == S_CLAIMED) | claim_ok);
  assign err_set[ERR_WRITE_UNCLAIMED]  = wr_req & hit_payload & (state == S_IDLE);

  assign ram_we     = wr_req & hit_payload & (state == S_CLAIMED);
  assign wb_stall_o = 1'b0;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      cpu_valid_o <= 1'b0;
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err         <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= '0;
      if (rd_req && hit_status) begin
        wb_dat_o <= status_word(full, empty, state == S_CLAIMED, 5'(count), 5'(g_entries));
      end else if (rd_req && hit_err) begin
        wb_dat_o <= 32'(err);
      end

      // A fresh error raised in the same cycle as the clearing read is kept.
      err         <= ((rd_req && hit_err) ? 3'b000 : err) | err_set;
      cpu_valid_o <= (wr_ptr != rd_ptr);

      if (purge) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        state  <= S_IDLE;
      end else begin
        if (discard_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (commit_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= S_IDLE;
        end else if (claim_ok) begin
          state <= S_CLAIMED;
        end
      end
    end
  end

  wrnc_hmq_dpram #(
    .g_depth  (g_entries * g_entry_words),
    .g_addr_w (RAM_AW)
  ) u_ram (
    .clk   (clk_sys_i),
    .we    (ram_we),
    .waddr ({wr_ptr[ENT_W-1:0], wb_adr_i[WORD_W-1:0]}),
    .sel   (wb_sel_i),
    .wdata (wb_dat_i),
    .raddr ({rd_ptr[ENT_W-1:0], cpu_rd_addr_i}),
    .rdata (cpu_rd_data_o)
  );

endmodule

// File: tb/tb_wrnc_hmq_in_slot.sv
// Self-checking bench for wrnc_hmq_in_slot against an operation-level queue model.
module tb_wrnc_hmq_in_slot;

  localparam int N = 4;
  localparam int W = 16;
  localparam logic [9:0] A_CMD    = 10'h000;
  localparam logic [9:0] A_STATUS = 10'h001;
  localparam logic [9:0] A_ERR    = 10'h002;
  localparam logic [9:0] A_PAY    = 10'h200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [9:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_stall_o, cpu_valid_o;
  logic [3:0]  cpu_rd_addr = '0;
  logic [31:0] cpu_rd_data_o;
  logic        cpu_discard = 1'b0;

  always #5 clk = ~clk;

  wrnc_hmq_in_slot #(.g_entries(N), .g_entry_words(W)) dut (
    .clk_sys_i     (clk),
    .rst_sys_i     (rst),
    .wb_cyc_i      (wb_cyc),
    .wb_stb_i      (wb_stb),
    .wb_we_i       (wb_we),
    .wb_sel_i      (wb_sel),
    .wb_adr_i      (wb_adr),
    .wb_dat_i      (wb_dat),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .wb_stall_o    (wb_stall_o),
    .cpu_valid_o   (cpu_valid_o),
    .cpu_rd_addr_i (cpu_rd_addr),
    .cpu_rd_data_o (cpu_rd_data_o),
    .cpu_discard_i (cpu_discard)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: entry contents, committed-entry counters and sticky error bits.
  logic [31:0] m_mem [N][W];
  int          m_wr, m_rd;
  bit          m_claimed;
  logic [2:0]  m_err;

  logic [31:0] rdata;
  logic        ack;

  function automatic int m_count();
    return m_wr - m_rd;
  endfunction

  function automatic logic [31:0] m_status();
    int c;
    c = m_count();
    return (32'(N) << 16) | (32'(c) << 8) | (32'(m_claimed) << 2) |
           ((c == 0) ? 32'h2 : 32'h0) | ((c == N) ? 32'h1 : 32'h0);
  endfunction

  task automatic m_reset();
    m_wr = 0; m_rd = 0; m_claimed = 0; m_err = '0;
  endtask

  task automatic bus(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic disc);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    cpu_discard = disc;
    @(negedge clk);
    ack = wb_ack_o; rdata = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; cpu_discard = 1'b0;
  endtask

  task automatic op_cmd(input logic [2:0] c, input logic disc);
    bit dok;
    dok = disc && (m_count() > 0) && !c[2];
    if (c[2]) begin
      m_wr = 0; m_rd = 0; m_claimed = 0;
    end else begin
      if (c[0] && !m_claimed) begin
        if (m_count() == N) m_err[0] = 1'b1;
        else m_claimed = 1;
      end
      if (c[1]) begin
        if (m_claimed) begin m_wr++; m_claimed = 0; end
        else m_err[1] = 1'b1;
      end
    end
    if (dok) m_rd++;
    bus(1'b1, A_CMD, {29'b0, c}, 4'hf, disc);
  endtask

  task automatic op_write(input int i, input logic [31:0] d, input logic [3:0] sel);
    if (i < W) begin
      if (m_claimed) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_mem[m_wr % N][i][8*b +: 8] = d[8*b +: 8];
      end else begin
        m_err[2] = 1'b1;
      end
    end
    bus(1'b1, 10'(int'(A_PAY) + i), d, sel, 1'b0);
  endtask

  task automatic op_discard();
    if (m_count() > 0) m_rd++;
    @(negedge clk); cpu_discard = 1'b1;
    @(negedge clk); cpu_discard = 1'b0;
  endtask

  task automatic cpu_read(input int a, output logic [31:0] d);
    @(negedge clk); cpu_rd_addr = 4'(a);
    @(negedge clk); d = cpu_rd_data_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = A_STATUS;
    @(negedge clk);
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_dat: got %h expected 0", wb_dat_o); end
    checks++; if (cpu_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", cpu_valid_o); end
    wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
    m_reset();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL reset_status_ack: got %b expected 1", ack); end
    checks++; if (rdata !== 32'h0004_0002) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00040002", rdata); end
    bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_err: got %h expected 0", rdata); end
  endtask

  task automatic test_basic();
    logic [31:0] d, exp;
    int a;
    op_cmd(3'b001, 1'b0);
    for (int i = 0; i < W; i++) op_write(i, 32'hA000 + 32'(i), 4'hf);
    op_cmd(3'b010, 1'b0);
    @(negedge clk);
    checks++; if (cpu_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", cpu_valid_o); end
    cpu_read(5, d);
    checks++; if (d !== 32'h0000_A005) begin errors++; $display("[TB] FAIL basic_word5: got %h expected 0000a005", d); end
    for (int k = 0; k < 3; k++) begin
      a = $urandom_range(0, W - 1);
      exp = m_mem[m_rd % N][a];
      cpu_read(a, d);
      checks++; if (d !== exp) begin errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h", a, d, exp); end
    end
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL basic_status: got %h expected %h", rdata, exp); end
    op_discard();
    @(negedge clk);
    checks++; if (cpu_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_after_pop: got %b expected 0", cpu_valid_o); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d, exp;
    op_cmd(3'b001, 1'b0);
    op_write(0, 32'h1122_3344, 4'hf);
    op_write(0, 32'h0000_5500, 4'b0010);
    op_cmd(3'b010, 1'b0);
    exp = m_mem[m_rd % N][0];
    cpu_read(0, d);
    checks++; if (d !== exp) begin errors++; $display("[TB] FAIL byte_write: got %h expected %h", d, exp); end
    op_discard();
  endtask

  task automatic test_full();
    logic [31:0] d, exp;
    int a;
    for (int e = 0; e < N; e++) begin
      op_cmd(3'b001, 1'b0);
      for (int i = 0; i < W; i++) op_write(i, $urandom, 4'hf);
      op_write($urandom_range(0, W - 1), $urandom, 4'($urandom_range(0, 15)));
      op_cmd(3'b010, 1'b0);
    end
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL full_status: got %h expected %h", rdata, exp); end
    op_cmd(3'b001, 1'b0);
    exp = m_err; m_err = '0;
    bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL full_err: got %h expected %h", rdata, exp); end
    exp = m_err; m_err = '0;
    bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL full_err_cleared: got %h expected %h", rdata, exp); end
    op_discard();
    op_cmd(3'b001, 1'b0);
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL full_reclaim: got %h expected %h", rdata, exp); end
    op_write(3, $urandom, 4'hf);
    op_cmd(3'b010, 1'b0);
    while (m_count() > 0) begin
      a = $urandom_range(0, W - 1);
      exp = m_mem[m_rd % N][a];
      cpu_read(a, d);
      checks++; if (d !== exp) begin errors++; $display("[TB] FAIL drain_word%0d: got %h expected %h", a, d, exp); end
      op_discard();
    end
    @(negedge clk);
    checks++; if (cpu_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b expected 0", cpu_valid_o); end
  endtask

  task automatic test_errors();
    logic [31:0] d, exp;
    op_write(2, 32'hDEAD_BEEF, 4'hf);
    op_cmd(3'b010, 1'b0);
    exp = m_err; m_err = '0;
    bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL unclaimed_err: got %h expected %h", rdata, exp); end
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL unclaimed_status: got %h expected %h", rdata, exp); end
    op_cmd(3'b011, 1'b0);
    @(negedge clk);
    checks++; if (cpu_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL claim_commit_valid: got %b expected 1", cpu_valid_o); end
    exp = m_mem[m_rd % N][2];
    cpu_read(2, d);
    checks++; if (d !== exp) begin errors++; $display("[TB] FAIL ram_untouched: got %h expected %h", d, exp); end
    op_discard();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp;
    for (int e = 0; e < 2; e++) begin
      op_cmd(3'b001, 1'b0);
      op_write(1, $urandom, 4'hf);
      op_cmd(3'b010, 1'b0);
    end
    op_cmd(3'b001, 1'b0);
    op_write(1, $urandom, 4'hf);
    op_cmd(3'b010, 1'b1);
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL commit_discard_status: got %h expected %h", rdata, exp); end
    exp = m_mem[m_rd % N][1];
    cpu_read(1, d);
    checks++; if (d !== exp) begin errors++; $display("[TB] FAIL commit_discard_head: got %h expected %h", d, exp); end
    op_cmd(3'b010, 1'b0);
    op_cmd(3'b100, 1'b1);
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL purge_status: got %h expected %h", rdata, exp); end
    checks++; if (cpu_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL purge_valid: got %b expected 0", cpu_valid_o); end
    exp = m_err; m_err = '0;
    bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL purge_err_kept: got %h expected %h", rdata, exp); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    logic [2:0]  c;
    logic [9:0]  adr;
    int a;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 10))
        0: begin
          c = 3'($urandom_range(0, 7));
          if (c[2] && $urandom_range(0, 3) != 0) c[2] = 1'b0;
          op_cmd(c, 1'($urandom_range(0, 1)));
        end
        1, 2, 3: op_write($urandom_range(0, W + 1), $urandom, 4'($urandom_range(0, 15)));
        4: op_discard();
        5: begin
          exp = m_status();
          bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
          checks++; if (rdata !== exp || ack !== 1'b1) begin errors++; $display("[TB] FAIL rand_status: got %h ack %b expected %h", rdata, ack, exp); end
        end
        6: begin
          exp = m_err; m_err = '0;
          bus(1'b0, A_ERR, 32'h0, 4'hf, 1'b0);
          checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL rand_err: got %h expected %h", rdata, exp); end
        end
        7: if (m_count() > 0) begin
          a = $urandom_range(0, W - 1);
          exp = m_mem[m_rd % N][a];
          cpu_read(a, d);
          checks++; if (d !== exp) begin errors++; $display("[TB] FAIL rand_cpu_word%0d: got %h expected %h", a, d, exp); end
        end
        8: begin
          case ($urandom_range(0, 3))
            0: adr = A_CMD;
            1: adr = 10'h003;
            2: adr = 10'(int'(A_PAY) + $urandom_range(0, W - 1));
            default: adr = 10'h150;
          endcase
          bus(1'b0, adr, 32'h0, 4'hf, 1'b0);
          checks++; if (rdata !== 32'h0 || ack !== 1'b1) begin errors++; $display("[TB] FAIL rand_zero_read %h: got %h ack %b expected 0", adr, rdata, ack); end
        end
        9: begin
          @(negedge clk);
          checks++; if (cpu_valid_o !== (m_count() != 0)) begin errors++; $display("[TB] FAIL rand_valid: got %b expected %b", cpu_valid_o, m_count() != 0); end
        end
        default: begin
          case ($urandom_range(0, 2))
            0: adr = A_STATUS;
            1: adr = A_ERR;
            default: adr = 10'h0F0;
          endcase
          bus(1'b1, adr, $urandom, 4'hf, 1'b0);
        end
      endcase
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] exp;
    op_cmd(3'b001, 1'b0);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = A_CMD; wb_dat = 32'h2; rst = 1'b1;
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL midflight_ack: got %b expected 0", wb_ack_o); end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    exp = m_status();
    bus(1'b0, A_STATUS, 32'h0, 4'hf, 1'b0);
    checks++; if (rdata !== exp) begin errors++; $display("[TB] FAIL midflight_status: got %h expected %h", rdata, exp); end
    checks++; if (cpu_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midflight_valid: got %b expected 0", cpu_valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_write();
    test_full();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
